// File: rtl/mdu_param.sv
// mdu_param: multiply/divide unit for the E stage. Owns HI/LO.
//   mult/multu/div/divu run for a fixed MULT_CYCLES / DIV_CYCLES busy window.
//   mthi/mtlo complete in one cycle.
//   A flush cancels an in-flight op and leaves HI/LO at their pre-op values.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start, MDU_op    MDU instruction valid in E and its operation select
//   flush            cancel the running op and ignore a same-cycle start
//   rs_data, rt_data operand A (dividend / mthi-mtlo source), operand B (divisor)
//   busy             a multi-cycle op is in flight (registered)
//   stall_req        busy | (start & md-op), to the hazard unit (combinational)
//   HI, LO           architectural HI/LO registers
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDU_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [2:0] OP_MTLO  = 3'b000;
    localparam logic [2:0] OP_MTHI  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo;
    logic             pend_wr;   // cleared for divide-by-zero so HI/LO stay put

    logic is_md;
    assign is_md = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) ||
                   (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
    assign stall_req = busy | (start & is_md);

    // Products: sign/zero-extend to 2*WIDTH; the low 2*WIDTH bits of the
    // extended product are the exact signed/unsigned product.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    assign prod_s = {{WIDTH{rs_data[WIDTH-1]}}, rs_data} * {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

    // Signed divide done on magnitudes. MIN_INT / -1 falls out naturally:
    // |MIN_INT| as unsigned is MIN_INT, quotient sign positive -> MIN_INT, rem 0.
    logic [WIDTH-1:0] a_abs, b_abs, uq, ur, sq, sr, q_u, r_u;
    always_comb begin
        a_abs = rs_data[WIDTH-1] ? -rs_data : rs_data;
        b_abs = rt_data[WIDTH-1] ? -rt_data : rt_data;
        uq    = '0;
        ur    = '0;
        q_u   = '0;
        r_u   = '0;
        if (b_abs != '0) begin
            uq = a_abs / b_abs;
            ur = a_abs % b_abs;
        end
        if (rt_data != '0) begin
            q_u = rs_data / rt_data;
            r_u = rs_data % rt_data;
        end
        sq = (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) ? -uq : uq;
        sr = rs_data[WIDTH-1] ? -ur : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (MDU_op)
                            OP_MULT, OP_MULTU: begin
                                {pend_hi, pend_lo} <= (MDU_op == OP_MULT) ? prod_s : prod_u;
                                pend_wr <= 1'b1;
                                cnt     <= CW'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_lo <= (MDU_op == OP_DIV) ? sq : q_u;
                                pend_hi <= (MDU_op == OP_DIV) ? sr : r_u;
                                pend_wr <= (rt_data != '0);
                                cnt     <= CW'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_MTHI: HI <= rs_data;
                            OP_MTLO: LO <= rs_data;
                            default: ;  // reserved: no-op
                        endcase
                    end
                end
                RUN: begin
                    // Any start here is dropped; hazard unit keeps it from happening.
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        pend_wr <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_param.sv
module tb_mdu_param;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  MDU_op;
    logic [31:0] rs_data, rt_data, HI, LO;
    logic        busy, stall_req;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] rs16, rt16, hi16, lo16;
    logic        busy16, stall16;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDU_op(MDU_op), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .stall_req(stall_req),
        .HI(HI), .LO(LO));

    mdu_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .MDU_op(op16), .flush(1'b0),
        .rs_data(rs16), .rt_data(rt16), .busy(busy16), .stall_req(stall16),
        .HI(hi16), .LO(lo16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an md-op, then count busy cycles (bounded) until the result is visible.
    task automatic md32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
        int c;
        start = 1'b1; MDU_op = op; rs_data = a; rt_data = b;
        #1 chk({tag, "_stall"}, 64'(stall_req), 64'(1));
        step();
        start = 1'b0;
        c = 0;
        while (busy && c < 100) begin
            c++;
            step();
        end
        chk({tag, "_busycyc"}, 64'(c), 64'(n));
    endtask

    task automatic single32(input logic [2:0] op, input logic [31:0] a, input logic fl);
        start = 1'b1; MDU_op = op; rs_data = a; flush = fl;
        step();
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; MDU_op = 3'b000;
        rs_data = '0; rt_data = '0;
        start16 = 1'b0; op16 = 3'b000; rs16 = '0; rt16 = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_hi", 64'(HI), 64'(0));
        chk("rst_lo", 64'(LO), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_stall", 64'(stall_req), 64'(0));

        // mult -2 x 3
        md32(3'b011, 32'hFFFF_FFFE, 32'd3, 5, "mult");
        chk("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(LO), 64'hFFFF_FFFA);

        md32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
        chk("multu_hi", 64'(HI), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(LO), 64'h0000_0001);

        md32(3'b101, 32'hFFFF_FFF9, 32'd2, 10, "div");
        chk("div_lo", 64'(LO), 64'hFFFF_FFFD);
        chk("div_hi", 64'(HI), 64'hFFFF_FFFF);

        md32(3'b100, 32'd7, 32'd2, 10, "divu");
        chk("divu_lo", 64'(LO), 64'd3);
        chk("divu_hi", 64'(HI), 64'd1);

        md32(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf");
        chk("divovf_lo", 64'(LO), 64'h8000_0000);
        chk("divovf_hi", 64'(HI), 64'd0);

        // divide by zero: full busy window, HI/LO untouched
        md32(3'b101, 32'd55, 32'd0, 10, "div0");
        chk("div0_lo", 64'(LO), 64'h8000_0000);
        chk("div0_hi", 64'(HI), 64'd0);
        md32(3'b100, 32'd55, 32'd0, 10, "divu0");
        chk("divu0_lo", 64'(LO), 64'h8000_0000);

        // mthi with same-cycle flush is dropped
        start = 1'b1; MDU_op = 3'b001; rs_data = 32'h1234; flush = 1'b1;
        #1 chk("mthi_fl_stall", 64'(stall_req), 64'(0));
        step();
        start = 1'b0; flush = 1'b0;
        chk("mthi_fl_hi", 64'(HI), 64'd0);
        chk("mthi_fl_busy", 64'(busy), 64'(0));

        // mthi without flush
        single32(3'b001, 32'h1234, 1'b0);
        chk("mthi_hi", 64'(HI), 64'h1234);
        chk("mthi_lo", 64'(LO), 64'h8000_0000);
        chk("mthi_busy", 64'(busy), 64'(0));

        // mtlo
        single32(3'b000, 32'h0BAD_F00D, 1'b0);
        chk("mtlo_lo", 64'(LO), 64'h0BAD_F00D);
        chk("mtlo_hi", 64'(HI), 64'h1234);

        // reserved op: no state change, no stall
        start = 1'b1; MDU_op = 3'b110; rs_data = 32'h99;
        #1 chk("rsv_stall", 64'(stall_req), 64'(0));
        step();
        start = 1'b0;
        chk("rsv_hi", 64'(HI), 64'h1234);
        chk("rsv_lo", 64'(LO), 64'h0BAD_F00D);
        chk("rsv_busy", 64'(busy), 64'(0));

        // mtlo while busy is dropped
        start = 1'b1; MDU_op = 3'b010; rs_data = 32'd3; rt_data = 32'd4;
        step();
        start = 1'b1; MDU_op = 3'b000; rs_data = 32'hDEAD;
        #1 chk("mtlob_stall", 64'(stall_req), 64'(1));
        step();
        start = 1'b0;
        chk("mtlob_lo_mid", 64'(LO), 64'h0BAD_F00D);
        for (int i = 0; i < 20 && busy; i++) step();
        chk("mtlob_busy", 64'(busy), 64'(0));
        chk("mtlob_lo", 64'(LO), 64'd12);
        chk("mtlob_hi", 64'(HI), 64'd0);

        // flush in busy cycle 4 of a div
        start = 1'b1; MDU_op = 3'b101; rs_data = 32'd100; rt_data = 32'd7;
        step();                          // busy cycle 1
        start = 1'b0;
        step(); step(); step();          // busy cycle 4
        chk("fl_busy_pre", 64'(busy), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_busy", 64'(busy), 64'(0));
        chk("fl_hi", 64'(HI), 64'd0);
        chk("fl_lo", 64'(LO), 64'd12);
        md32(3'b011, 32'd5, 32'd6, 5, "postfl");
        chk("postfl_lo", 64'(LO), 64'd30);
        chk("postfl_hi", 64'(HI), 64'd0);

        // reset in busy cycle 2 of a mult
        single32(3'b001, 32'h77, 1'b0);
        start = 1'b1; MDU_op = 3'b011; rs_data = 32'd7; rt_data = 32'd7;
        step();                          // busy cycle 1
        start = 1'b0;
        step();                          // busy cycle 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_busy", 64'(busy), 64'(0));
        chk("rmid_hi", 64'(HI), 64'd0);
        chk("rmid_lo", 64'(LO), 64'd0);
        for (int i = 0; i < 8; i++) step();
        chk("rmid_lo_late", 64'(LO), 64'd0);

        // 16-bit instance: MULT_CYCLES=1, DIV_CYCLES=3
        begin
            int c;
            start16 = 1'b1; op16 = 3'b011; rs16 = 16'hFFFE; rt16 = 16'd3;
            #1 chk("m16_stall", 64'(stall16), 64'(1));
            step();
            start16 = 1'b0;
            c = 0;
            while (busy16 && c < 50) begin c++; step(); end
            chk("m16_busycyc", 64'(c), 64'(1));
            chk("m16_hi", 64'(hi16), 64'hFFFF);
            chk("m16_lo", 64'(lo16), 64'hFFFA);

            start16 = 1'b1; op16 = 3'b101; rs16 = 16'hFFF9; rt16 = 16'd2;
            step();
            start16 = 1'b0;
            c = 0;
            while (busy16 && c < 50) begin c++; step(); end
            chk("d16_busycyc", 64'(c), 64'(3));
            chk("d16_lo", 64'(lo16), 64'hFFFD);
            chk("d16_hi", 64'(hi16), 64'hFFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mdu_param.md
Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined MIPS core. It owns the HI/LO registers.
- Executes mult, multu, div and divu with configurable fixed latencies, and mthi/mtlo in a single cycle.
- Reports busy and stall status to the hazard unit so that mfhi/mflo and further MDU instructions wait.
- Supports flush on exception, which cancels an in-flight operation without touching HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>= 2).
- MULT_CYCLES, 5, busy cycles for mult/multu (>= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (>= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  MDU instruction valid in E this cycle; MDU_op is meaningful only when start=1.
- MDU_op  input  3  operation select: 011 mult, 010 multu, 101 div, 100 divu, 001 mthi, 000 mtlo; 110 and 111 are reserved and treated as no-op.
- flush  input  1  exception/flush; cancels the current op and suppresses a same-cycle start.
- rs_data  input  WIDTH  operand A (dividend, or source for mthi/mtlo).
- rt_data  input  WIDTH  operand B (divisor).
- busy  output  1  a multi-cycle operation is in flight.
- stall_req  output  1  busy | (start & md-op), where md-op = mult/multu/div/divu; consumed by the hazard unit.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (reset=1 at a clock edge):
  - HI=0, LO=0, busy=0, counter=0, pending results cleared.
  - reset has priority over flush and start.
  - reset mid-operation abandons the op; HI/LO become 0.
- States: IDLE and RUN.
  - Internal counter is ceil(log2(max(MULT_CYCLES, DIV_CYCLES) + 1)) bits wide.
- IDLE, start=1, flush=0, md-op:
  - The result is computed from operands sampled at this edge and held in pending registers.
  - counter loads N (MULT_CYCLES or DIV_CYCLES); state becomes RUN.
  - busy=1 for exactly N cycles, starting the cycle after start.
- RUN:
  - counter decrements each edge.
  - At the edge where counter == 1: HI/LO take the pending values, busy goes 0, state returns to IDLE.
  - New HI/LO are visible in the first cycle busy=0. Latency from start to visible result is N+1 edges.
- start while busy=1 is ignored, including mthi/mtlo. The hazard unit guarantees this does not happen; the bench checks that the op is dropped.
- mthi/mtlo (start=1, flush=0, busy=0):
  - HI or LO <= rs_data at that edge; the other register is unchanged.
  - No busy cycle; visible next cycle.
- flush=1:
  - Any RUN operation is aborted: state becomes IDLE and busy=0 at that edge.
  - HI/LO keep their pre-op values.
  - A same-cycle start, including mthi/mtlo, is ignored.
- Arithmetic:
  - mult: signed WIDTH x WIDTH -> 2*WIDTH; HI = upper word, LO = lower word.
  - multu: unsigned, same split.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - div, MIN_INT / -1: LO = MIN_INT, HI = 0.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div or divu): the op still occupies DIV_CYCLES busy cycles, but HI/LO are left unchanged at completion.
- Reserved MDU_op with start=1: no state change; stall_req follows the md-op rule, so it stays 0 unless busy.
- stall_req is combinational; busy, HI and LO are registered outputs.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE (-2), rt=3 (WIDTH=32, MULT_CYCLES=5) -> busy high for 5 cycles; in cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_req=1 in the start cycle.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after MULT_CYCLES+1 edges.
- div -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu 7/2 -> LO=3, HI=1.
- div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- div x/0 -> busy for 10 cycles, then HI/LO unchanged.
- mthi 0x1234 with a same-cycle flush -> HI unchanged.
- mthi 0x1234 without flush -> HI=0x1234 next cycle, busy never asserted.
- mtlo issued while busy -> LO unaffected until the running op completes.
- Start div, assert flush in busy cycle 4 -> busy=0 next cycle; HI/LO equal their pre-div values; a following mult starts normally.
- Assert reset in busy cycle 2 of a mult -> next cycle busy=0, HI=0, LO=0.
- Re-run with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3: mult -2 x 3 -> busy for exactly 1 cycle, then HI=0xFFFF, LO=0xFFFA.
